voice_allocator: RTL and testbench

//   Polyphony scheduler in front of the total_tone_generator voice bank.

---
 rtl/voice_alloc_pkg.sv | 29 ++
 rtl/voice_select.sv | 43 ++++
 rtl/voice_allocator.sv | 208 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared types and helpers for the voice allocator.
//   NOTE_W        width of a note number (MIDI-style 0..127)
//   BASE_NOTE_DEF default note number of key 0 at octave 0
//   KEY_W         width of a stored key index (up to 16 keys)
//   note_t, key_t note / key scalar types
//   evt_t         one note event: {valid, on, note, key}
//   key_to_note   key index + octave offset -> note number
package voice_alloc_pkg;

    localparam int NOTE_W        = 7;
    localparam int BASE_NOTE_DEF = 48;
    localparam int KEY_W         = 4;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [KEY_W-1:0]  key_t;

    typedef struct packed {
        logic  valid;
        logic  on;
        note_t note;
        key_t  key;
    } evt_t;

    function automatic note_t key_to_note(input key_t key, input logic [1:0] octave,
                                          input note_t base);
        return base + note_t'(octave) * note_t'(12) + note_t'(key);
    endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker.
//   voice_gate  in   current gate per voice
//   ages        in   packed per-voice ages, voice v at [IDX_W*v +: IDX_W]
//   free_idx    out  lowest-index voice whose gate is 0
//   free_found  out  1 when at least one voice is free
//   steal_idx   out  voice with the largest age (oldest assignment)
module voice_select #(
    parameter int N_VOICES = 4,
    parameter int IDX_W    = 2
) (
    input  logic [N_VOICES-1:0]       voice_gate,
    input  logic [N_VOICES*IDX_W-1:0] ages,
    output logic [IDX_W-1:0]          free_idx,
    output logic                      free_found,
    output logic [IDX_W-1:0]          steal_idx
);

    logic [IDX_W-1:0] best_age;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned v = 0; v < N_VOICES; v++) begin
            if (!voice_gate[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
        end
    end

    // Ages form a permutation of 0..N_VOICES-1, so the maximum is unique.
    always_comb begin
        best_age  = ages[IDX_W-1:0];
        steal_idx = '0;
        for (int unsigned v = 1; v < N_VOICES; v++) begin
            if (ages[v*IDX_W +: IDX_W] > best_age) begin
                best_age  = ages[v*IDX_W +: IDX_W];
                steal_idx = IDX_W'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler in front of the tone-generator voice bank.
// Key presses (GPIO_0, SW=0) or UART note events (SW=1) become note-on/off
// commands that claim and free one of N_VOICES voices.
//   CLOCK_50    in   system clock, rising edge
//   reset       in   synchronous, active-high
//   GPIO_0      in   debounced key levels, 1=pressed
//   octave_sel  in   octave offset applied when a press is served
//   SW          in   source select: 0=GPIO keys, 1=UART events
//   uart_valid  in   uart_data holds an event
//   uart_data   in   [7]=on/off, [6:0]=note number
//   uart_ready  out  event accepted when uart_valid && uart_ready
//   voice_note  out  note per voice, voice v at [7v+6:7v]
//   voice_gate  out  1=voice sounding
//   voice_full  out  all voices gated
// Build option: define VOICE_STEAL_EN to steal the oldest voice when none is
// free; otherwise such an event is dropped.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int N_VOICES  = 4,
    parameter int N_KEYS    = 12,
    parameter int BASE_NOTE = BASE_NOTE_DEF
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [N_KEYS-1:0]          GPIO_0,
    input  logic [1:0]                 octave_sel,
    input  logic                       SW,
    input  logic                       uart_valid,
    input  logic [7:0]                 uart_data,
    output logic                       uart_ready,
    output logic [NOTE_W*N_VOICES-1:0] voice_note,
    output logic [N_VOICES-1:0]        voice_gate,
    output logic                       voice_full
);

    localparam int IDX_W = $clog2(N_VOICES);

`ifdef VOICE_STEAL_EN
    localparam logic STEAL_EN = 1'b1;
`else
    localparam logic STEAL_EN = 1'b0;
`endif

    logic [N_KEYS-1:0]         gpio_q, press_pend, rel_pend;
    logic [N_KEYS-1:0]         rise, fall, served_press, served_rel;
    logic [N_KEYS-1:0]         press_nx, rel_nx, cancel;
    logic                      sw_q, flush;
    note_t                     note_r [N_VOICES];
    key_t                      key_r  [N_VOICES];
    logic [IDX_W-1:0]          age_r  [N_VOICES];
    logic [N_VOICES-1:0]       gate_r, gate_nx;
    logic [N_VOICES*IDX_W-1:0] ages_flat;
    evt_t                      evt;
    logic                      match_found;
    logic [IDX_W-1:0]          match_idx;
    logic [IDX_W-1:0]          free_idx, steal_idx, victim, victim_age;
    logic                      free_found, do_alloc, do_free;

    // A source change costs one cycle in which everything is cleared.
    assign flush = (SW != sw_q);
    assign rise  = GPIO_0 & ~gpio_q;
    assign fall  = ~GPIO_0 & gpio_q;

    // Event mux: UART passes straight through; GPIO serves releases before
    // presses, lowest key first.
    always_comb begin
        evt          = '0;
        served_rel   = '0;
        served_press = '0;
        if (SW) begin
            evt.valid = uart_valid && uart_ready;
            evt.on    = uart_data[7];
            evt.note  = uart_data[6:0];
        end else if (|rel_pend) begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                if (rel_pend[k] && !evt.valid) begin
                    evt.valid     = 1'b1;
                    evt.key       = key_t'(k);
                    served_rel[k] = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                if (press_pend[k] && !evt.valid) begin
                    evt.valid       = 1'b1;
                    evt.on          = 1'b1;
                    evt.key         = key_t'(k);
                    evt.note        = key_to_note(key_t'(k), octave_sel, note_t'(BASE_NOTE));
                    served_press[k] = 1'b1;
                end
            end
        end
    end

    // Pending masks after this cycle; a press and release on the same key cancel.
    always_comb begin
        press_nx = (press_pend & ~served_press) | rise;
        rel_nx   = (rel_pend & ~served_rel) | fall;
        cancel   = press_nx & rel_nx;
        press_nx = press_nx & ~cancel;
        rel_nx   = rel_nx & ~cancel;
    end

    // GPIO voices are matched by key so an octave change while held cannot
    // orphan them; UART voices are matched by note.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned v = 0; v < N_VOICES; v++) begin
            if (gate_r[v] && !match_found &&
                (SW ? (note_r[v] == evt.note) : (key_r[v] == evt.key))) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(v);
            end
        end
    end

    always_comb begin
        ages_flat = '0;
        for (int unsigned v = 0; v < N_VOICES; v++)
            ages_flat[v*IDX_W +: IDX_W] = age_r[v];
    end

    voice_select #(
        .N_VOICES (N_VOICES),
        .IDX_W    (IDX_W)
    ) u_select (
        .voice_gate (gate_r),
        .ages       (ages_flat),
        .free_idx   (free_idx),
        .free_found (free_found),
        .steal_idx  (steal_idx)
    );

    assign victim   = free_found ? free_idx : steal_idx;
    assign do_alloc = evt.valid && evt.on && !match_found && (free_found || STEAL_EN);
    assign do_free  = evt.valid && !evt.on && match_found;

    always_comb begin
        gate_nx    = gate_r;
        victim_age = '0;
        for (int unsigned v = 0; v < N_VOICES; v++) begin
            if (IDX_W'(v) == victim)
                victim_age = age_r[v];
            if (do_alloc && IDX_W'(v) == victim)
                gate_nx[v] = 1'b1;
            if (do_free && IDX_W'(v) == match_idx)
                gate_nx[v] = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            gpio_q     <= '0;
            press_pend <= '0;
            rel_pend   <= '0;
            sw_q       <= 1'b0;
            uart_ready <= 1'b0;
            gate_r     <= '0;
            voice_full <= 1'b0;
            for (int unsigned v = 0; v < N_VOICES; v++) begin
                note_r[v] <= '0;
                key_r[v]  <= '0;
                age_r[v]  <= IDX_W'(v);
            end
        end else if (flush) begin
            sw_q       <= SW;
            gpio_q     <= '0;
            press_pend <= '0;
            rel_pend   <= '0;
            uart_ready <= 1'b0;
            gate_r     <= '0;
            voice_full <= 1'b0;
        end else begin
            uart_ready <= SW;
            if (!SW) begin
                gpio_q     <= GPIO_0;
                press_pend <= press_nx;
                rel_pend   <= rel_nx;
            end
            // Newly assigned voice becomes youngest; only voices younger than
            // its previous age move up, keeping ages a permutation.
            for (int unsigned v = 0; v < N_VOICES; v++) begin
                if (do_alloc) begin
                    if (IDX_W'(v) == victim) begin
                        note_r[v] <= evt.note;
                        key_r[v]  <= evt.key;
                        age_r[v]  <= '0;
                    end else if (age_r[v] < victim_age) begin
                        age_r[v]  <= age_r[v] + IDX_W'(1);
                    end
                end
            end
            gate_r     <= gate_nx;
            voice_full <= &gate_nx;
        end
    end

    always_comb begin
        voice_note = '0;
        for (int unsigned v = 0; v < N_VOICES; v++)
            voice_note[v*NOTE_W +: NOTE_W] = note_r[v];
    end

    assign voice_gate = gate_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator with a recency-stamp voice model.
module tb_voice_allocator;

    localparam int NV   = 4;
    localparam int NK   = 12;
    localparam int BASE = 48;

    logic            CLOCK_50 = 1'b0;
    logic            reset = 1'b1;
    logic [NK-1:0]   GPIO_0 = '0;
    logic [1:0]      octave_sel = '0;
    logic            SW = 1'b0;
    logic            uart_valid = 1'b0;
    logic [7:0]      uart_data = '0;
    logic            uart_ready;
    logic [7*NV-1:0] voice_note;
    logic [NV-1:0]   voice_gate;
    logic            voice_full;

    voice_allocator #(.N_VOICES(NV), .N_KEYS(NK), .BASE_NOTE(BASE)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .GPIO_0     (GPIO_0),
        .octave_sel (octave_sel),
        .SW         (SW),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .voice_note (voice_note),
        .voice_gate (voice_gate),
        .voice_full (voice_full)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each voice remembers note, key, gate and when it was last assigned.
    int            m_note  [NV];
    bit            m_gate  [NV];
    int            m_key   [NV];
    int            m_stamp [NV];
    int            stamp_ctr;
    logic [NK-1:0] prev_keys;

    function automatic logic [7*NV-1:0] exp_notes();
        logic [7*NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v*7 +: 7] = 7'(m_note[v]);
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_gates();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_gate[v];
        return r;
    endfunction

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_note[v] = 0; m_gate[v] = 0; m_key[v] = 0; m_stamp[v] = -v;
        end
        stamp_ctr = 1;
        prev_keys = '0;
    endtask

    task automatic m_flush();
        for (int v = 0; v < NV; v++) m_gate[v] = 0;
        prev_keys = '0;
    endtask

    task automatic m_alloc(input int note, input int key);
        int sel = -1;
        for (int v = 0; v < NV; v++) if (!m_gate[v] && sel < 0) sel = v;
        if (sel < 0) begin
`ifdef VOICE_STEAL_EN
            sel = 0;
            for (int v = 1; v < NV; v++) if (m_stamp[v] < m_stamp[sel]) sel = v;
`else
            return;
`endif
        end
        m_note[sel] = note; m_key[sel] = key; m_gate[sel] = 1;
        m_stamp[sel] = stamp_ctr;
        stamp_ctr++;
    endtask

    task automatic m_release_key(input int k);
        for (int v = 0; v < NV; v++)
            if (m_gate[v] && m_key[v] == k) begin m_gate[v] = 0; return; end
    endtask

    task automatic m_note_on(input int n);
        for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == n) return;
        m_alloc(n, 0);
    endtask

    task automatic m_note_off(input int n);
        for (int v = 0; v < NV; v++)
            if (m_gate[v] && m_note[v] == n) begin m_gate[v] = 0; return; end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; GPIO_0 = '0; SW = 1'b0; uart_valid = 1'b0; octave_sel = '0;
        tick(); tick();
        reset = 1'b0;
        m_reset();
    endtask

    // Change the key vector and wait until every resulting event is served.
    task automatic gpio_drive(input logic [NK-1:0] keys, input logic [1:0] oct);
        logic [NK-1:0] f, r;
        f = prev_keys & ~keys;
        r = keys & ~prev_keys;
        for (int k = 0; k < NK; k++) if (f[k]) m_release_key(k);
        for (int k = 0; k < NK; k++) if (r[k]) m_alloc(BASE + 12*int'(oct) + k, k);
        GPIO_0 = keys; octave_sel = oct;
        repeat ($countones(f | r) + 2) tick();
        prev_keys = keys;
    endtask

    task automatic uart_send(input logic [7:0] b);
        int w = 0;
        while (!uart_ready && w < 8) begin tick(); w++; end
        if (!uart_ready) begin
            n_chk++; n_fail++;
            $display("FAIL uart_ready_timeout: got %b want 1", uart_ready);
        end else begin
            uart_valid = 1'b1; uart_data = b;
            tick();
            uart_valid = 1'b0;
            if (b[7]) m_note_on(int'(b[6:0])); else m_note_off(int'(b[6:0]));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; GPIO_0 = '1; SW = 1'b0;
        tick(); tick();
        n_chk++; if (voice_note !== '0) begin n_fail++; $display("FAIL reset_note: got %h want 0", voice_note); end
        n_chk++; if (voice_gate !== '0) begin n_fail++; $display("FAIL reset_gate: got %b want 0", voice_gate); end
        n_chk++; if (voice_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", voice_full); end
        n_chk++; if (uart_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", uart_ready); end
        GPIO_0 = '0; reset = 1'b0;
        m_reset();
    endtask

    task automatic test_gpio_latency();
        do_reset();
        GPIO_0 = 12'h001; octave_sel = 2'd0;
        tick();
        n_chk++; if (voice_gate !== 4'b0000) begin n_fail++; $display("FAIL latency_early: got %b want 0000", voice_gate); end
        tick();
        n_chk++; if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd48) begin
            n_fail++; $display("FAIL latency_press: gate %b note %0d want 0001 48", voice_gate, voice_note[6:0]);
        end
        m_alloc(48, 0); prev_keys = 12'h001;
    endtask

    task automatic test_gpio_chord();
        do_reset();
        gpio_drive(12'h091, 2'd1);
        n_chk++; if (voice_gate !== 4'b0111 || voice_note[20:0] !== {7'd67, 7'd64, 7'd60}) begin
            n_fail++; $display("FAIL chord_on: gate %b notes %h want 0111 %h", voice_gate, voice_note[20:0], {7'd67, 7'd64, 7'd60});
        end
        gpio_drive(12'h090, 2'd1);
        n_chk++; if (voice_gate !== 4'b0110 || voice_note[20:0] !== {7'd67, 7'd64, 7'd60}) begin
            n_fail++; $display("FAIL chord_release: gate %b notes %h want 0110 %h", voice_gate, voice_note[20:0], {7'd67, 7'd64, 7'd60});
        end
    endtask

    task automatic test_full();
        logic [27:0] want5;
        do_reset();
        gpio_drive(12'h001, 2'd0); gpio_drive(12'h003, 2'd0);
        gpio_drive(12'h007, 2'd0); gpio_drive(12'h00F, 2'd0);
        n_chk++; if (voice_note !== {7'd51, 7'd50, 7'd49, 7'd48} || voice_full !== 1'b1) begin
            n_fail++; $display("FAIL full_four: notes %h full %b want %h 1", voice_note, voice_full, {7'd51, 7'd50, 7'd49, 7'd48});
        end
`ifdef VOICE_STEAL_EN
        want5 = {7'd51, 7'd50, 7'd49, 7'd52};
`else
        want5 = {7'd51, 7'd50, 7'd49, 7'd48};
`endif
        gpio_drive(12'h01F, 2'd0);
        n_chk++; if (voice_note !== want5 || voice_gate !== 4'b1111 || voice_full !== 1'b1) begin
            n_fail++; $display("FAIL full_fifth: notes %h gate %b full %b want %h 1111 1", voice_note, voice_gate, voice_full, want5);
        end
        gpio_drive(12'h00F, 2'd0);
        n_chk++; if (voice_note !== exp_notes() || voice_gate !== exp_gates() || voice_full !== &exp_gates()) begin
            n_fail++; $display("FAIL full_release_fifth: gate %b full %b want %b %b", voice_gate, voice_full, exp_gates(), &exp_gates());
        end
    endtask

    task automatic test_uart();
        do_reset();
        SW = 1'b1; tick(); m_flush();
        uart_send(8'hBC);
        n_chk++; if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd60) begin
            n_fail++; $display("FAIL uart_on: gate %b note %0d want 0001 60", voice_gate, voice_note[6:0]);
        end
        uart_send(8'hBC);
        n_chk++; if (voice_gate !== 4'b0001) begin n_fail++; $display("FAIL uart_dup: gate %b want 0001", voice_gate); end
        uart_send(8'h3C);
        n_chk++; if (voice_gate !== 4'b0000) begin n_fail++; $display("FAIL uart_off: gate %b want 0000", voice_gate); end
        uart_send(8'h3D);
        n_chk++; if (voice_gate !== 4'b0000 || voice_note[6:0] !== 7'd60) begin
            n_fail++; $display("FAIL uart_off_nomatch: gate %b note %0d want 0000 60", voice_gate, voice_note[6:0]);
        end
    endtask

    task automatic test_switch();
        uart_send(8'hBC); uart_send(8'hBE);
        GPIO_0 = 12'h005;
        repeat (3) tick();
        n_chk++; if (voice_gate !== 4'b0011) begin n_fail++; $display("FAIL gpio_ignored: gate %b want 0011", voice_gate); end
        SW = 1'b0; tick(); m_flush();
        n_chk++; if (voice_gate !== 4'b0000 || uart_ready !== 1'b0 || voice_full !== 1'b0) begin
            n_fail++; $display("FAIL flush_to_gpio: gate %b ready %b full %b want 0000 0 0", voice_gate, uart_ready, voice_full);
        end
        gpio_drive(12'h005, 2'd2);
        n_chk++; if (voice_note !== exp_notes() || voice_gate !== exp_gates() || voice_gate !== 4'b0011) begin
            n_fail++; $display("FAIL retrigger: notes %h gate %b want %h %b", voice_note, voice_gate, exp_notes(), exp_gates());
        end
        gpio_drive(12'h000, 2'd2);
        SW = 1'b1; tick(); m_flush();
        n_chk++; if (uart_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", uart_ready); end
        tick();
        n_chk++; if (uart_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_flush: got %b want 1", uart_ready); end
    endtask

    task automatic test_random_gpio();
        logic [NK-1:0] keys;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            keys = prev_keys ^ (NK'($urandom) & NK'($urandom) & NK'($urandom));
            gpio_drive(keys, 2'($urandom_range(0, 3)));
            n_chk++;
            if (voice_note !== exp_notes() || voice_gate !== exp_gates() ||
                voice_full !== &exp_gates() || uart_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_gpio[%0d]: notes %h gate %b full %b ready %b want %h %b %b 0",
                         i, voice_note, voice_gate, voice_full, uart_ready, exp_notes(), exp_gates(), &exp_gates());
            end
        end
    endtask

    task automatic test_random_uart();
        logic [7:0] b;
        do_reset();
        SW = 1'b1; tick(); m_flush();
        for (int i = 0; i < 40; i++) begin
            b = {1'($urandom_range(0, 1)), 7'(60 + $urandom_range(0, 5))};
            uart_send(b);
            n_chk++;
            if (voice_note !== exp_notes() || voice_gate !== exp_gates() ||
                voice_full !== &exp_gates() || uart_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_uart[%0d] evt %h: notes %h gate %b full %b ready %b want %h %b %b 1",
                         i, b, voice_note, voice_gate, voice_full, uart_ready, exp_notes(), exp_gates(), &exp_gates());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        GPIO_0 = 12'hFFF; octave_sel = 2'd1;
        tick(); tick();
        reset = 1'b1; GPIO_0 = '0;
        tick();
        n_chk++; if (voice_gate !== '0 || voice_note !== '0 || voice_full !== 1'b0 || uart_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: gate %b note %h full %b ready %b want all 0", voice_gate, voice_note, voice_full, uart_ready);
        end
        reset = 1'b0;
        repeat (6) tick();
        n_chk++; if (voice_gate !== '0 || voice_note !== '0) begin
            n_fail++; $display("FAIL reset_mid_late: gate %b note %h want 0 0", voice_gate, voice_note);
        end
        m_reset();
    endtask

    initial begin
        test_reset();
        test_gpio_latency();
        test_gpio_chord();
        test_full();
        test_uart();
        test_switch();
        test_random_gpio();
        test_random_uart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
